checkpoint_seq_monitor: RTL and testbench

Synthesizable on-chip replacement for the bench-side "wait for checkbits value" sequence.
- Watches a WIDTH-bit GPIO field, such as mprj_io[31:16].
- Matches it in order against a programmable table of up to DEPTH expected values.
- Applies a per-step timeout and a glitch filter.
- Reports pass or fail with a failure code, plus a cycle timestamp for each match.
- Sits in the user project area, next to the LA/Wishbone config logic that loads the table.

---
 rtl/checkpoint_mon_pkg.sv | 17 +
 rtl/mon_stable_filter.sv | 37 +++
 rtl/checkpoint_seq_monitor.sv | 168 ++++++++++++++++
 tb/tb_checkpoint_seq_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checkpoint_mon_pkg.sv
// Shared types for the checkpoint sequence monitor: FSM states and the
// failure codes reported on fail_code_o.
package checkpoint_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } mon_state_e;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_TIMEOUT = 2'd1;
   localparam logic [1:0] FC_ORDER   = 2'd2;
   localparam logic [1:0] FC_BADLEN  = 2'd3;

endpackage

// File: rtl/mon_stable_filter.sv
// Glitch filter for the monitored field: registers the input once and fires a
// single accept pulse when a value has been stable for HOLD cycles.
module mon_stable_filter #(
   parameter int WIDTH = 16,
   parameter int HOLD  = 2
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [WIDTH-1:0] mon,
   output logic [WIDTH-1:0] mon_q,
   output logic             accept
);

   localparam int CW = $clog2(HOLD + 2);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD);
   localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD + 1);

   logic [CW-1:0] stable_cnt;

   // Counter parks one past HOLD so each stable run yields exactly one accept.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         mon_q      <= '0;
         stable_cnt <= '0;
      end else begin
         mon_q <= mon;
         if (mon != mon_q)
            stable_cnt <= CNT_ONE;
         else if (stable_cnt != CNT_SAT)
            stable_cnt <= stable_cnt + CNT_ONE;
      end
   end

   assign accept = (stable_cnt == CNT_HOLD);

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Matches a filtered GPIO field against a programmable checkpoint table in order,
// with per-step timeout, optional strict ordering, sticky status and stamps.
//
//   state | meaning
//   IDLE  | not armed; table writable
//   RUN   | matching table[step]; table writes dropped
//   PASS  | all len entries matched; status held
//   FAIL  | timeout, out-of-order or bad length; status held
module checkpoint_seq_monitor
   import checkpoint_mon_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int TW     = 32,
   parameter int HOLD   = 2,
   parameter bit STRICT = 1'b0,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [WIDTH-1:0] mon_i,
   input  logic             cfg_we_i,
   input  logic [AW-1:0]    cfg_addr_i,
   input  logic [WIDTH-1:0] cfg_data_i,
   input  logic [AW:0]      cfg_len_i,
   input  logic [TW-1:0]    timeout_i,
   input  logic             start_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic [1:0]       fail_code_o,
   output logic [AW:0]      step_o,
   output logic             match_stb_o,
   output logic [TW-1:0]    stamp_o
);

   localparam logic [AW:0]   STEP_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
   localparam logic [TW-1:0] TW_ONE   = TW'(1);

   logic [WIDTH-1:0] table_mem [DEPTH];
   mon_state_e       state_q, state_d;
   logic [AW:0]      len_q;
   logic [AW:0]      step_inc;
   logic [TW-1:0]    cyc_q, step_tmr_q;
   logic [WIDTH-1:0] mon_val;
   logic             accept, hit, order_err, tmo_hit, len_bad;

   mon_stable_filter #(.WIDTH(WIDTH), .HOLD(HOLD)) u_filter (
      .clk_sys (wb_clk_i),
      .rst     (wb_rst_i),
      .mon     (mon_i),
      .mon_q   (mon_val),
      .accept  (accept)
   );

   assign step_inc = step_o + STEP_ONE;
   assign len_bad  = (cfg_len_i == '0) || (cfg_len_i > DEPTH_W);

   always_ff @(posedge wb_clk_i) begin
      if (cfg_we_i && (state_q != RUN) && ({1'b0, cfg_addr_i} < DEPTH_W))
         table_mem[cfg_addr_i] <= cfg_data_i;
   end

   always_comb begin
      state_d   = state_q;
      hit       = 1'b0;
      order_err = 1'b0;
      tmo_hit   = 1'b0;
      if (state_q == RUN) begin
         hit = accept && (mon_val == table_mem[step_o[AW-1:0]]);
         if (accept && STRICT) begin
            for (int k = 0; k < DEPTH; k++) begin
               if ((k > int'(step_o)) && (k < int'(len_q)) && (table_mem[k] == mon_val))
                  order_err = 1'b1;
            end
         end
         tmo_hit = (timeout_i != '0) && (step_tmr_q == timeout_i - TW_ONE);
      end
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            RUN: begin
               if (hit) begin
                  if (step_inc == len_q)
                     state_d = PASS;
               end else if (order_err || tmo_hit) begin
                  state_d = FAIL;
               end
            end
            default: begin
               if (start_i)
                  state_d = len_bad ? FAIL : RUN;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cyc_q       <= '0;
         step_tmr_q  <= '0;
         busy_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         fail_code_o <= FC_NONE;
         step_o      <= '0;
         match_stb_o <= 1'b0;
         stamp_o     <= '0;
      end else begin
         state_q     <= state_d;
         busy_o      <= (state_d == RUN);
         match_stb_o <= 1'b0;
         if (abort_i) begin
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_code_o <= FC_NONE;
            step_o      <= '0;
         end else begin
            case (state_q)
               RUN: begin
                  if (cyc_q != '1)
                     cyc_q <= cyc_q + TW_ONE;
                  step_tmr_q <= step_tmr_q + TW_ONE;
                  // Priority: match, then ordering violation, then timeout.
                  if (hit) begin
                     match_stb_o <= 1'b1;
                     stamp_o     <= cyc_q;
                     step_o      <= step_inc;
                     step_tmr_q  <= '0;
                     if (step_inc == len_q)
                        pass_o <= 1'b1;
                  end else if (order_err) begin
                     fail_o      <= 1'b1;
                     fail_code_o <= FC_ORDER;
                  end else if (tmo_hit) begin
                     fail_o      <= 1'b1;
                     fail_code_o <= FC_TIMEOUT;
                  end
               end
               default: begin
                  if (start_i) begin
                     if (len_bad) begin
                        pass_o      <= 1'b0;
                        fail_o      <= 1'b1;
                        fail_code_o <= FC_BADLEN;
                     end else begin
                        len_q       <= cfg_len_i;
                        step_o      <= '0;
                        cyc_q       <= '0;
                        step_tmr_q  <= '0;
                        stamp_o     <= '0;
                        pass_o      <= 1'b0;
                        fail_o      <= 1'b0;
                        fail_code_o <= FC_NONE;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: a relaxed (STRICT=0) and a strict (STRICT=1)
// instance share all stimulus and are compared every cycle against a reference model.
module tb_checkpoint_seq_monitor;

   localparam int HOLD   = 2;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_PASS = 2;
   localparam int S_FAIL = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mon;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic [3:0]  cfg_len;
   logic [31:0] tmo;
   logic        start;
   logic        abort;

   logic        busy_w  [2];
   logic        pass_w  [2];
   logic        fail_w  [2];
   logic        stb_w   [2];
   logic [1:0]  code_w  [2];
   logic [3:0]  step_w  [2];
   logic [31:0] stamp_w [2];

   int vectors = 0;
   int errs    = 0;

   // reference model state, one set per instance
   int          m_state [2];
   logic [3:0]  m_len   [2];
   logic [3:0]  m_step  [2];
   logic [31:0] m_cyc   [2];
   logic [31:0] m_tmr   [2];
   logic [31:0] m_stamp [2];
   bit          m_pass  [2];
   bit          m_fail  [2];
   bit          m_stb   [2];
   logic [1:0]  m_code  [2];
   logic [15:0] m_tab   [2][8];
   logic [15:0] hist    [$];

   logic [15:0] vals [6] = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51};

   always #5 clk = ~clk;

   checkpoint_seq_monitor #(.STRICT(1'b0)) dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .mon_i(mon), .cfg_we_i(cfg_we),
      .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_len_i(cfg_len),
      .timeout_i(tmo), .start_i(start), .abort_i(abort), .busy_o(busy_w[0]),
      .pass_o(pass_w[0]), .fail_o(fail_w[0]), .fail_code_o(code_w[0]),
      .step_o(step_w[0]), .match_stb_o(stb_w[0]), .stamp_o(stamp_w[0]));

   checkpoint_seq_monitor #(.STRICT(1'b1)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .mon_i(mon), .cfg_we_i(cfg_we),
      .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_len_i(cfg_len),
      .timeout_i(tmo), .start_i(start), .abort_i(abort), .busy_o(busy_w[1]),
      .pass_o(pass_w[1]), .fail_o(fail_w[1]), .fail_code_o(code_w[1]),
      .step_o(step_w[1]), .match_stb_o(stb_w[1]), .stamp_o(stamp_w[1]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s at %0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = S_IDLE; m_len[i] = '0; m_step[i] = '0; m_cyc[i] = '0;
         m_tmr[i] = '0; m_stamp[i] = '0; m_pass[i] = 0; m_fail[i] = 0;
         m_stb[i] = 0; m_code[i] = '0;
      end
      hist.delete();
   endtask

   task automatic model_fsm(input int i, input bit acc, input logic [15:0] val);
      bit wr_ok;
      bit later;
      wr_ok = cfg_we && (m_state[i] != S_RUN);
      later = 0;
      m_stb[i] = 0;
      if (abort) begin
         m_state[i] = S_IDLE; m_pass[i] = 0; m_fail[i] = 0; m_code[i] = 0; m_step[i] = 0;
      end else if (m_state[i] == S_RUN) begin
         for (int k = int'(m_step[i]) + 1; k < int'(m_len[i]); k++)
            if (m_tab[i][k] == val) later = 1;
         if (acc && val == m_tab[i][m_step[i]]) begin
            m_stb[i] = 1; m_stamp[i] = m_cyc[i]; m_step[i] = m_step[i] + 4'd1; m_tmr[i] = 0;
            if (m_step[i] == m_len[i]) begin m_state[i] = S_PASS; m_pass[i] = 1; end
         end else if (acc && i == 1 && later) begin
            m_state[i] = S_FAIL; m_fail[i] = 1; m_code[i] = 2'd2;
         end else if (tmo != 0 && m_tmr[i] == tmo - 32'd1) begin
            m_state[i] = S_FAIL; m_fail[i] = 1; m_code[i] = 2'd1;
         end else begin
            m_tmr[i] = m_tmr[i] + 32'd1;
         end
         if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 32'd1;
      end else if (start) begin
         if (cfg_len == 0 || cfg_len > 8) begin
            m_state[i] = S_FAIL; m_pass[i] = 0; m_fail[i] = 1; m_code[i] = 2'd3;
         end else begin
            m_state[i] = S_RUN; m_len[i] = cfg_len; m_step[i] = 0; m_cyc[i] = 0;
            m_tmr[i] = 0; m_stamp[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_code[i] = 0;
         end
      end
      if (wr_ok) m_tab[i][cfg_addr] = cfg_data;
   endtask

   // A value is accepted once it has appeared on HOLD consecutive sampled cycles
   // following a different value (or following reset).
   task automatic model_edge();
      bit acc;
      logic [15:0] val;
      int n;
      n = hist.size();
      val = (n > 0) ? hist[n-1] : 16'h0000;
      acc = 0;
      if (n >= HOLD) begin
         acc = 1;
         for (int j = n - HOLD; j < n; j++) if (hist[j] != val) acc = 0;
         if (n > HOLD && hist[n-HOLD-1] == val) acc = 0;
      end
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) model_fsm(i, acc, val);
         hist.push_back(mon);
         if (hist.size() > 8) void'(hist.pop_front());
      end
   endtask

   task automatic tick();
      logic [63:0] obs, exp;
      model_edge();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         obs = {22'd0, busy_w[i], pass_w[i], fail_w[i], code_w[i], step_w[i], stb_w[i], stamp_w[i]};
         exp = {22'd0, m_state[i] == S_RUN, m_pass[i], m_fail[i], m_code[i], m_step[i], m_stb[i], m_stamp[i]};
         check(i == 0 ? "cycle_relaxed" : "cycle_strict", obs, exp);
      end
   endtask

   task automatic hold(input logic [15:0] v, input int n);
      mon = v;
      repeat (n) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cfg_we = 1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 0;
   endtask

   task automatic go(input logic [3:0] len, input logic [31:0] t);
      cfg_len = len; tmo = t; start = 1;
      tick();
      start = 0;
   endtask

   task automatic pulse_abort();
      abort = 1;
      tick();
      abort = 0;
   endtask

   initial begin
      rst = 1; mon = 16'h1111; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
      cfg_len = '0; tmo = '0; start = 0; abort = 0;
      for (int i = 0; i < 2; i++) for (int k = 0; k < 8; k++) m_tab[i][k] = '0;
      model_reset();
      repeat (3) tick();
      check("reset_busy", busy_w[0], 0);
      check("reset_step", step_w[1], 0);
      rst = 0;
      for (int k = 0; k < 6; k++) wr(3'(k), vals[k]);
      wr(3'd6, 16'h9999);
      wr(3'd7, 16'h9999);
      hold(16'h1111, 3);

      // happy path
      go(4'd6, 0);
      for (int k = 0; k < 6; k++) hold(vals[k], 5);
      for (int i = 0; i < 2; i++) begin
         check("happy_step", step_w[i], 6);
         check("happy_pass", pass_w[i], 1);
         check("happy_code", code_w[i], 0);
      end
      hold(16'h1111, 3);

      // glitch rejection and accept latency
      go(4'd6, 0);
      hold(16'hAB40, 5);
      hold(16'h003E, 1);
      hold(16'h1111, 4);
      check("glitch_step", step_w[0], 1);
      mon = 16'h003E;
      tick(); check("lat_c1", stb_w[0], 0);
      tick(); check("lat_c2", stb_w[0], 0);
      tick(); check("lat_c3", stb_w[0], 1);
      check("lat_step", step_w[1], 2);
      pulse_abort();
      hold(16'h1111, 3);

      // timeout after step 2
      go(4'd6, 100);
      hold(16'hAB40, 5);
      hold(16'h003E, 5);
      hold(16'h1111, 97);
      check("tmo_early", fail_w[0], 0);
      tick();
      check("tmo_fail", fail_w[0], 1);
      check("tmo_code", code_w[1], 1);
      check("tmo_step", step_w[0], 2);

      // match landing in the timeout cycle
      go(4'd6, 100);
      hold(16'h1111, 97);
      hold(16'hAB40, 5);
      check("tmo_edge_fail", fail_w[0], 0);
      check("tmo_edge_step", step_w[0], 1);
      pulse_abort();
      hold(16'h1111, 3);

      // strict ordering
      go(4'd6, 0);
      hold(16'h0044, 5);
      check("strict_fail", fail_w[1], 1);
      check("strict_code", code_w[1], 2);
      check("relaxed_busy", busy_w[0], 1);
      hold(16'hAB40, 5);
      hold(16'h003E, 5);
      check("relaxed_step", step_w[0], 2);
      pulse_abort();
      hold(16'h1111, 3);

      // bad lengths
      go(4'd0, 0);
      check("len0_code", code_w[0], 3);
      go(4'd9, 0);
      check("len9_code", code_w[1], 3);
      check("len9_fail", fail_w[1], 1);

      // write during RUN is dropped
      go(4'd2, 0);
      wr(3'd1, 16'h7777);
      hold(16'hAB40, 5);
      hold(16'h003E, 5);
      check("runwr_pass", pass_w[0], 1);

      // two identical consecutive entries
      wr(3'd1, 16'hAB40);
      hold(16'h1111, 3);
      go(4'd2, 0);
      hold(16'hAB40, 10);
      check("dup_step1", step_w[0], 1);
      hold(16'h1111, 3);
      hold(16'hAB40, 5);
      check("dup_pass", pass_w[1], 1);

      // value already stable at start is not matched
      wr(3'd1, 16'h003E);
      go(4'd2, 0);
      hold(16'hAB40, 10);
      check("stable_step", step_w[0], 0);
      check("stable_busy", busy_w[0], 1);
      pulse_abort();

      // start and table write in the same cycle
      cfg_we = 1; cfg_addr = 3'd0; cfg_data = 16'h5555;
      go(4'd1, 0);
      cfg_we = 0;
      hold(16'h5555, 5);
      check("startwr_pass", pass_w[0], 1);
      wr(3'd0, 16'hAB40);

      // abort mid-run, then restart
      hold(16'h1111, 3);
      go(4'd6, 0);
      hold(16'hAB40, 5);
      pulse_abort();
      check("abort_busy", busy_w[0], 0);
      check("abort_step", step_w[0], 0);
      check("abort_pf", {pass_w[1], fail_w[1]}, 0);
      hold(16'h1111, 3);
      go(4'd2, 0);
      hold(16'hAB40, 5);
      hold(16'h003E, 5);
      check("abort_restart", pass_w[0], 1);

      // reset mid-run, then restart
      hold(16'h1111, 3);
      go(4'd6, 0);
      hold(16'hAB40, 5);
      rst = 1;
      tick();
      rst = 0;
      check("rst_busy", busy_w[1], 0);
      check("rst_step", step_w[1], 0);
      hold(16'h1111, 3);
      go(4'd2, 0);
      hold(16'hAB40, 5);
      hold(16'h003E, 5);
      check("rst_restart", pass_w[1], 1);

      // randomized traffic
      for (int seg = 0; seg < 300; seg++) begin
         int r;
         int n;
         r = $urandom_range(0, 9);
         mon = (r < 6) ? vals[r] : ((r < 8) ? 16'h1111 : 16'($urandom));
         n = $urandom_range(1, 6);
         for (int c = 0; c < n; c++) begin
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_data = vals[$urandom_range(0, 5)];
            start    = ($urandom_range(0, 15) == 0);
            cfg_len  = 4'($urandom_range(0, 9));
            tmo      = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(4, 40));
            abort    = ($urandom_range(0, 63) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
         end
      end
      cfg_we = 0; start = 0; abort = 0; rst = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
